// File: rtl/mtm_alu_result_checker.sv
// In-order result checker for MTM ALU benches: queues expected responses, compares
// each decoded DUT response against the queue head and keeps saturating statistics.
module mtm_alu_result_checker #(
  parameter int DATA_W  = 32,
  parameter int FLAG_W  = 6,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       exp_valid,
  output logic                       exp_ready,
  input  logic                       exp_err,
  input  logic [FLAG_W-1:0]          exp_flags,
  input  logic [DATA_W-1:0]          exp_data,
  input  logic                       act_valid,
  input  logic                       act_err,
  input  logic [FLAG_W-1:0]          act_flags,
  input  logic [DATA_W-1:0]          act_data,
  input  logic                       clr_stats,
  output logic                       chk_valid,
  output logic                       chk_fail,
  output logic [4:0]                 chk_kind,
  output logic [CNT_W-1:0]           frame_ctr,
  output logic [CNT_W-1:0]           error_ctr,
  output logic [CNT_W-1:0]           timeout_ctr,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     pending
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit TMO_EN = (TIMEOUT > 0);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [PW-1:0]     count;
  logic              mem_err   [DEPTH];
  logic [FLAG_W-1:0] mem_flags [DEPTH];
  logic [DATA_W-1:0] mem_data  [DEPTH];
  logic [TMR_W-1:0]  timer;

  logic       full, empty, tmo_fire, pop, push, drop;
  logic       res_valid, res_fail;
  logic [4:0] cmp_kind, res_kind;

  assign full      = (count == PW'(DEPTH));
  assign empty     = (count == '0);
  assign exp_ready = !full;
  assign pending   = count;

  // An arriving response always wins over an expiring timer in the same cycle.
  assign tmo_fire = TMO_EN && !empty && !act_valid && (timer == TMR_LAST);
  assign pop      = (act_valid && !empty) || tmo_fire;
  assign push     = exp_valid && (!full || pop);
  assign drop     = exp_valid && full && !pop;

  always_comb begin
    cmp_kind = 5'b00000;
    if (mem_err[rd_ptr] != act_err) begin
      cmp_kind[0] = 1'b1;
    end else begin
      cmp_kind[1] = (mem_flags[rd_ptr] != act_flags);
      cmp_kind[2] = !act_err && (mem_data[rd_ptr] != act_data);
    end
  end

  always_comb begin
    res_kind = 5'b00000;
    if (act_valid) res_kind = empty ? 5'b01000 : cmp_kind;
    else if (tmo_fire) res_kind = 5'b10000;
  end

  assign res_valid = act_valid || tmo_fire;
  assign res_fail  = |res_kind;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_err[wr_ptr]   <= exp_err;
      mem_flags[wr_ptr] <= exp_flags;
      mem_data[wr_ptr]  <= exp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      timer  <= '0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + PW'(1);
        2'b01:   count <= count - PW'(1);
        default: count <= count;
      endcase
      if (act_valid || empty || tmo_fire) timer <= '0;
      else if (TMO_EN) timer <= timer + TMR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chk_valid <= 1'b0;
      chk_fail  <= 1'b0;
      chk_kind  <= 5'b00000;
    end else begin
      chk_valid <= res_valid;
      chk_fail  <= res_fail;
      chk_kind  <= res_kind;
    end
  end

  // Statistics saturate at all-ones; a clear in the same cycle beats any increment.
  always_ff @(posedge clk) begin
    if (reset || clr_stats) begin
      frame_ctr   <= '0;
      error_ctr   <= '0;
      timeout_ctr <= '0;
      overflow    <= 1'b0;
    end else begin
      if (res_valid && (frame_ctr != '1))   frame_ctr   <= frame_ctr + CNT_W'(1);
      if (res_fail && (error_ctr != '1))    error_ctr   <= error_ctr + CNT_W'(1);
      if (tmo_fire && (timeout_ctr != '1))  timeout_ctr <= timeout_ctr + CNT_W'(1);
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mtm_alu_result_checker.sv
// Bench for mtm_alu_result_checker: directed scenarios followed by random traffic,
// all checked every cycle against a queue-based reference model.
module tb_mtm_alu_result_checker;

  localparam int DATA_W  = 32;
  localparam int FLAG_W  = 6;
  localparam int DEPTH   = 8;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 16;
  localparam int CNT_MAX = 15;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              exp_valid = 1'b0, exp_err = 1'b0;
  logic [FLAG_W-1:0] exp_flags = '0;
  logic [DATA_W-1:0] exp_data = '0;
  logic              act_valid = 1'b0, act_err = 1'b0;
  logic [FLAG_W-1:0] act_flags = '0;
  logic [DATA_W-1:0] act_data = '0;
  logic              clr_stats = 1'b0;
  logic              exp_ready, chk_valid, chk_fail, overflow;
  logic [4:0]        chk_kind;
  logic [CNT_W-1:0]  frame_ctr, error_ctr, timeout_ctr;
  logic [3:0]        pending;

  mtm_alu_result_checker #(
    .DATA_W(DATA_W), .FLAG_W(FLAG_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_err(exp_err),
    .exp_flags(exp_flags), .exp_data(exp_data),
    .act_valid(act_valid), .act_err(act_err), .act_flags(act_flags), .act_data(act_data),
    .clr_stats(clr_stats),
    .chk_valid(chk_valid), .chk_fail(chk_fail), .chk_kind(chk_kind),
    .frame_ctr(frame_ctr), .error_ctr(error_ctr), .timeout_ctr(timeout_ctr),
    .overflow(overflow), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              err;
    bit [FLAG_W-1:0] flags;
    bit [DATA_W-1:0] data;
  } entry_t;

  entry_t     q[$];
  bit         m_valid;
  bit [4:0]   m_kind;
  int         m_frame, m_error, m_tmo, m_wait;
  bit         m_ovf;
  int         checks = 0;
  int         errors = 0;

  function automatic int sat_inc(int v);
    return (v < CNT_MAX) ? v + 1 : v;
  endfunction

  // Reference model: one call per clock edge, applying the block's rules to the inputs.
  task automatic modelStep(input bit ev, input entry_t e, input bit av, input entry_t a,
                           input bit clr, input bit rst);
    bit popped;
    bit was_full;
    bit dropped;
    popped  = 0;
    dropped = 0;
    if (rst) begin
      q.delete();
      m_valid = 0; m_kind = 0; m_wait = 0;
      m_frame = 0; m_error = 0; m_tmo = 0; m_ovf = 0;
      return;
    end
    m_valid = 0;
    m_kind  = 0;
    if (av) begin
      m_valid = 1;
      m_wait  = 0;
      if (q.size() == 0) m_kind = 5'b01000;
      else begin
        if (q[0].err != a.err) m_kind = 5'b00001;
        else begin
          if (q[0].flags != a.flags) m_kind[1] = 1;
          if (!a.err && q[0].data != a.data) m_kind[2] = 1;
        end
        popped = 1;
      end
    end else if (q.size() == 0) begin
      m_wait = 0;
    end else begin
      m_wait++;
      if (m_wait == TIMEOUT) begin
        m_valid = 1; m_kind = 5'b10000; popped = 1; m_wait = 0;
      end
    end
    was_full = (q.size() == DEPTH);
    if (popped) void'(q.pop_front());
    if (ev) begin
      if (!was_full || popped) q.push_back(e);
      else dropped = 1;
    end
    if (clr) begin
      m_frame = 0; m_error = 0; m_tmo = 0; m_ovf = 0;
    end else begin
      if (m_valid) m_frame = sat_inc(m_frame);
      if (m_kind != 0) m_error = sat_inc(m_error);
      if (m_kind == 5'b10000) m_tmo = sat_inc(m_tmo);
      if (dropped) m_ovf = 1;
    end
  endtask

  task automatic checkOutput(input string tag);
    checks++;
    assert (chk_valid === m_valid) else begin
      errors++; $error("FAIL %s chk_valid got=%0b want=%0b", tag, chk_valid, m_valid);
    end
    if (m_valid) begin
      checks++;
      assert (chk_fail === (m_kind != 0)) else begin
        errors++; $error("FAIL %s chk_fail got=%0b want=%0b", tag, chk_fail, m_kind != 0);
      end
      checks++;
      assert (chk_kind === m_kind) else begin
        errors++; $error("FAIL %s chk_kind got=%05b want=%05b", tag, chk_kind, m_kind);
      end
    end
    checks++;
    assert (pending === 4'(q.size())) else begin
      errors++; $error("FAIL %s pending got=%0d want=%0d", tag, pending, q.size());
    end
    checks++;
    assert (exp_ready === (q.size() != DEPTH)) else begin
      errors++; $error("FAIL %s exp_ready got=%0b want=%0b", tag, exp_ready, q.size() != DEPTH);
    end
    checks++;
    assert (overflow === m_ovf) else begin
      errors++; $error("FAIL %s overflow got=%0b want=%0b", tag, overflow, m_ovf);
    end
    checks++;
    assert (frame_ctr === 4'(m_frame)) else begin
      errors++; $error("FAIL %s frame_ctr got=%0d want=%0d", tag, frame_ctr, m_frame);
    end
    checks++;
    assert (error_ctr === 4'(m_error)) else begin
      errors++; $error("FAIL %s error_ctr got=%0d want=%0d", tag, error_ctr, m_error);
    end
    checks++;
    assert (timeout_ctr === 4'(m_tmo)) else begin
      errors++; $error("FAIL %s timeout_ctr got=%0d want=%0d", tag, timeout_ctr, m_tmo);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, step the model on the rising edge.
  task automatic applyStimulus(input string tag, input bit ev, input entry_t e,
                               input bit av, input entry_t a, input bit clr, input bit rst);
    @(negedge clk);
    reset     = rst;
    exp_valid = ev;  exp_err = e.err; exp_flags = e.flags; exp_data = e.data;
    act_valid = av;  act_err = a.err; act_flags = a.flags; act_data = a.data;
    clr_stats = clr;
    @(posedge clk);
    modelStep(ev, e, av, a, clr, rst);
    #1;
    checkOutput(tag);
  endtask

  function automatic entry_t mk(input bit err, input bit [FLAG_W-1:0] f, input bit [DATA_W-1:0] d);
    entry_t r;
    r.err = err; r.flags = f; r.data = d;
    return r;
  endfunction

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) applyStimulus(tag, 0, mk(0, 0, 0), 0, mk(0, 0, 0), 0, 0);
  endtask

  task automatic pushOnly(input string tag, input entry_t e);
    applyStimulus(tag, 1, e, 0, mk(0, 0, 0), 0, 0);
  endtask

  task automatic actOnly(input string tag, input entry_t a);
    applyStimulus(tag, 0, mk(0, 0, 0), 1, a, 0, 0);
  endtask

  task automatic drain(input string tag);
    while (q.size() > 0) actOnly(tag, q[0]);
  endtask

  initial begin
    entry_t e, a;
    bit ev, av, clr, rst;

    $display("[TB] reset");
    applyStimulus("reset", 0, mk(0, 0, 0), 0, mk(0, 0, 0), 0, 1);
    applyStimulus("reset", 0, mk(0, 0, 0), 0, mk(0, 0, 0), 0, 1);

    $display("[TB] single passing frame");
    pushOnly("pass_push", mk(0, 6'h00, 32'h3));
    idle("pass_wait", 4);
    actOnly("pass_act", mk(0, 6'h00, 32'h3));
    checks++;
    assert (frame_ctr === 4'd1 && error_ctr === 4'd0) else begin
      errors++; $error("FAIL pass_ctrs got=%0d/%0d want=1/0", frame_ctr, error_ctr);
    end

    $display("[TB] flags+data mismatch, then error frame ignoring data");
    pushOnly("mis_push", mk(0, 6'h04, 32'h5));
    actOnly("mis_act", mk(0, 6'h05, 32'h6));
    checks++;
    assert (chk_kind === 5'b00110) else begin
      errors++; $error("FAIL mis_kind got=%05b want=00110", chk_kind);
    end
    pushOnly("errf_push", mk(1, 6'h20, 32'h0));
    actOnly("errf_act", mk(1, 6'h20, 32'hDEAD));
    pushOnly("errbit_push", mk(1, 6'h01, 32'h0));
    actOnly("errbit_act", mk(0, 6'h01, 32'h0));

    $display("[TB] unexpected response with same-cycle push");
    applyStimulus("unexp", 1, mk(0, 6'h02, 32'h77), 1, mk(0, 6'h02, 32'h77), 0, 0);
    checks++;
    assert (chk_kind === 5'b01000 && pending === 4'd1) else begin
      errors++; $error("FAIL unexp kind=%05b pending=%0d want=01000/1", chk_kind, pending);
    end
    drain("unexp_drain");

    $display("[TB] fill and overflow");
    for (int i = 0; i < 9; i++) pushOnly("fill", mk(0, 6'(i), 32'(i * 3 + 1)));
    checks++;
    assert (overflow === 1'b1 && pending === 4'd8 && exp_ready === 1'b0) else begin
      errors++; $error("FAIL fill ovf=%0b pending=%0d ready=%0b want=1/8/0", overflow, pending, exp_ready);
    end
    applyStimulus("full_pushpop", 1, mk(0, 6'h3F, 32'hABCD), 1, q[0], 0, 0);
    drain("full_drain");

    $display("[TB] timeout");
    pushOnly("tmo_push", mk(0, 6'h08, 32'h9));
    idle("tmo_wait", 15);
    idle("tmo_fire", 1);
    checks++;
    assert (chk_kind === 5'b10000 && pending === 4'd0 && timeout_ctr === 4'd1) else begin
      errors++; $error("FAIL tmo kind=%05b pending=%0d tctr=%0d", chk_kind, pending, timeout_ctr);
    end
    pushOnly("tmo2_push", mk(0, 6'h01, 32'h7));
    idle("tmo2_wait", 15);
    actOnly("tmo2_act", mk(0, 6'h01, 32'h7));
    checks++;
    assert (chk_kind === 5'b00000 && timeout_ctr === 4'd1) else begin
      errors++; $error("FAIL tmo2 kind=%05b tctr=%0d", chk_kind, timeout_ctr);
    end

    $display("[TB] saturation, clear, reset");
    for (int i = 0; i < 20; i++) actOnly("sat", mk(0, 0, 32'(i)));
    checks++;
    assert (error_ctr === 4'hF) else begin
      errors++; $error("FAIL sat error_ctr got=%0h want=F", error_ctr);
    end
    applyStimulus("clr", 0, mk(0, 0, 0), 1, mk(0, 0, 0), 1, 0);
    for (int i = 0; i < 3; i++) pushOnly("pre_rst", mk(0, 6'(i), 32'(i)));
    applyStimulus("mid_rst", 0, mk(0, 0, 0), 1, q[0], 0, 1);
    idle("post_rst", 2);

    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) begin
      ev  = ($urandom_range(0, 99) < 40);
      av  = ($urandom_range(0, 99) < 30);
      clr = ($urandom_range(0, 99) < 2);
      rst = ($urandom_range(0, 399) == 0);
      e   = mk($urandom_range(0, 3) == 0, 6'($urandom), $urandom);
      if (q.size() > 0 && $urandom_range(0, 99) < 75) begin
        a = q[0];
        case ($urandom_range(0, 5))
          0: a.err   = ~a.err;
          1: a.flags = a.flags ^ 6'h10;
          2: a.data  = a.data ^ 32'h1;
          3: begin a.flags = ~a.flags; a.data = ~a.data; end
          default: ;
        endcase
      end else begin
        a = mk($urandom_range(0, 1), 6'($urandom), $urandom);
      end
      applyStimulus("random", ev, e, av, a, clr, rst);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
